// File: rtl/load_store_unit_if.sv
// Request/response and data_memory bus for the load/store unit.
// master: execute stage plus data_memory side; slave: the LSU itself.
interface load_store_unit_if #(
   parameter int WORDSIZE = 64
);
   // execute-stage request
   logic                req_valid;
   logic                req_ready;
   logic                is_store;
   logic [2:0]          funct3;
   logic [WORDSIZE-1:0] byte_addr;
   logic [WORDSIZE-1:0] store_data;

   // completion
   logic                resp_valid;
   logic [WORDSIZE-1:0] load_data;
   logic                fault;

   // data_memory port (word indexed, combinational read)
   logic [WORDSIZE-1:0] mem_addr;
   logic [WORDSIZE-1:0] mem_wdata;
   logic                mem_write_en;
   logic [WORDSIZE-1:0] mem_rdata;

   modport master (
      output req_valid, is_store, funct3, byte_addr, store_data, mem_rdata,
      input  req_ready, resp_valid, load_data, fault,
             mem_addr, mem_wdata, mem_write_en
   );

   modport slave (
      input  req_valid, is_store, funct3, byte_addr, store_data, mem_rdata,
      output req_ready, resp_valid, load_data, fault,
             mem_addr, mem_wdata, mem_write_en
   );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit driving a word-organised data_memory.
// Loads read one word and extract/extend the addressed lanes; SB/SH/SW
// perform read-modify-write; SD writes the word directly. Faulting
// requests respond after one cycle without touching memory.
module load_store_unit #(
   parameter int WORDSIZE = 64,
   parameter int SIZE     = 512
) (
   input  logic             clk,
   input  logic             reset,
   load_store_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [WORDSIZE-1:0] SIZE_W = WORDSIZE'(SIZE);

   state_t state;
   state_t state_next;

   // incoming request decode
   logic [WORDSIZE-1:0] req_word;
   logic [2:0]          req_off;
   logic                req_misaligned;
   logic                req_out_of_range;
   logic                req_illegal;
   logic                req_fault;
   logic                req_is_sd;

   // latched request
   logic                is_store_q;
   logic [2:0]          funct3_q;
   logic [2:0]          off_q;
   logic [WORDSIZE-1:0] store_data_q;

   // registered outputs
   logic [WORDSIZE-1:0] load_data_q;
   logic                fault_q;
   logic [WORDSIZE-1:0] mem_addr_q;
   logic [WORDSIZE-1:0] mem_wdata_q;

   // lane manipulation on the word currently read from memory
   logic [5:0]          lane_shift;
   logic [WORDSIZE-1:0] lane_mask;
   logic [WORDSIZE-1:0] lane_mask_sh;
   logic [WORDSIZE-1:0] merged_word;
   logic [WORDSIZE-1:0] shifted_word;
   logic [WORDSIZE-1:0] extracted;

   // Decode the request presented on the bus and classify faults.
   always_comb begin
      req_word = {3'b000, bus.byte_addr[WORDSIZE-1:3]};
      req_off  = bus.byte_addr[2:0];
      case (bus.funct3[1:0])
         2'b00:   req_misaligned = 1'b0;
         2'b01:   req_misaligned = req_off[0];
         2'b10:   req_misaligned = |req_off[1:0];
         default: req_misaligned = |req_off;
      endcase
      req_out_of_range = (req_word >= SIZE_W);
      req_illegal      = (bus.funct3 == 3'b111) || (bus.is_store && bus.funct3[2]);
      req_fault        = req_misaligned || req_out_of_range || req_illegal;
      req_is_sd        = bus.is_store && (bus.funct3 == 3'b011);
   end

   // Byte-lane merge (stores) and extraction/extension (loads).
   always_comb begin
      lane_shift = {off_q, 3'b000};
      case (funct3_q[1:0])
         2'b00:   lane_mask = {{(WORDSIZE-8){1'b0}},  8'hFF};
         2'b01:   lane_mask = {{(WORDSIZE-16){1'b0}}, 16'hFFFF};
         2'b10:   lane_mask = {{(WORDSIZE-32){1'b0}}, 32'hFFFF_FFFF};
         default: lane_mask = '1;
      endcase
      lane_mask_sh = lane_mask << lane_shift;
      merged_word  = (bus.mem_rdata & ~lane_mask_sh) |
                     ((store_data_q << lane_shift) & lane_mask_sh);

      shifted_word = bus.mem_rdata >> lane_shift;
      case (funct3_q)
         3'b000:  extracted = {{(WORDSIZE-8){shifted_word[7]}},   shifted_word[7:0]};
         3'b001:  extracted = {{(WORDSIZE-16){shifted_word[15]}}, shifted_word[15:0]};
         3'b010:  extracted = {{(WORDSIZE-32){shifted_word[31]}}, shifted_word[31:0]};
         3'b100:  extracted = {{(WORDSIZE-8){1'b0}},  shifted_word[7:0]};
         3'b101:  extracted = {{(WORDSIZE-16){1'b0}}, shifted_word[15:0]};
         3'b110:  extracted = {{(WORDSIZE-32){1'b0}}, shifted_word[31:0]};
         default: extracted = bus.mem_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (req_fault) begin
                  state_next = RESP;
               end else if (req_is_sd) begin
                  state_next = WRITE;
               end else begin
                  state_next = READ;
               end
            end
         end
         READ:    state_next = is_store_q ? WRITE : RESP;
         WRITE:   state_next = RESP;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded control outputs; write enable follows the async state reset.
   always_comb begin
      bus.req_ready    = (state == IDLE);
      bus.resp_valid   = (state == RESP);
      bus.mem_write_en = (state == WRITE);
   end

   // Request latch and datapath registers. The merged store word is formed
   // while the old word is on mem_rdata, so WRITE drives a registered value
   // that doubles as the buffered word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         is_store_q   <= 1'b0;
         funct3_q     <= '0;
         off_q        <= '0;
         store_data_q <= '0;
         load_data_q  <= '0;
         fault_q      <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  is_store_q   <= bus.is_store;
                  funct3_q     <= bus.funct3;
                  off_q        <= req_off;
                  store_data_q <= bus.store_data;
                  load_data_q  <= '0;
                  fault_q      <= req_fault;
                  if (!req_fault) begin
                     mem_addr_q <= req_word;
                     if (req_is_sd) begin
                        mem_wdata_q <= bus.store_data;
                     end
                  end
               end
            end
            READ: begin
               if (is_store_q) begin
                  mem_wdata_q <= merged_word;
               end else begin
                  load_data_q <= extracted;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.load_data = load_data_q;
   assign bus.fault     = fault_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access initiator that drives the word-organised data_memory (64-bit words; combinational read; write on posedge clk when write_en).
- Accepts RV64 load/store requests from the execute stage using byte addresses and funct3 size encoding.
- Converts each request to a word index and performs sign/zero-extended loads.
- Implements byte, half and word stores as a read-modify-write sequence; doubleword stores are written directly.

Parameters:
- WORDSIZE, 64, data word width in bits (fixed at 64 for RV64).
- SIZE, 512, number of words in data_memory; word indices are 0..SIZE-1.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU idle; a request is accepted when req_valid && req_ready at posedge clk.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU.
- byte_addr  input  WORDSIZE  byte address.
- store_data  input  WORDSIZE  store operand; only the low bytes are used for sub-word stores.
- resp_valid  output  1  one-cycle completion pulse.
- load_data  output  WORDSIZE  extended load result; valid while resp_valid is high.
- fault  output  1  valid with resp_valid: misaligned access, out-of-range address, or illegal funct3.
- mem_addr  output  WORDSIZE  word index to data_memory.
- mem_wdata  output  WORDSIZE  write data to data_memory.
- mem_write_en  output  1  data_memory write enable.
- mem_rdata  input  WORDSIZE  data_memory read data (combinational from mem_addr).

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE, req_ready = 1, resp_valid = 0, load_data = 0, fault = 0.
  - mem_addr = 0, mem_wdata = 0, mem_write_en = 0.
  - All internal request registers cleared.
- Reset asserted mid-operation aborts the access immediately. If it lands in the WRITE state, mem_write_en drops asynchronously, so no partial write occurs on the next edge.
- Acceptance: in IDLE with req_valid = 1 at a posedge, latch is_store, funct3, byte_addr and store_data. Compute word index = byte_addr >> 3 and byte offset = byte_addr[2:0].
- Fault check, performed at acceptance:
  - Misaligned if the offset is not a multiple of the access size (1, 2, 4 or 8 bytes).
  - Out-of-range if the word index >= SIZE.
  - Illegal if funct3 = 111, or if is_store is set and funct3 >= 100.
  - On any fault go to RESP with fault = 1, load_data = 0, and no memory access (mem_write_en never asserted).
- States:
  - IDLE: req_ready = 1, mem_write_en = 0.
  - READ: mem_addr = word index. At the end of the cycle, capture mem_rdata into a word buffer.
    - Load: next state is RESP.
    - Sub-word store: next state is WRITE.
  - WRITE: mem_addr = word index, mem_write_en = 1 for exactly one cycle.
    - SD: mem_wdata = store_data.
    - SB/SH/SW: mem_wdata = buffered word with bytes [offset .. offset+size-1] replaced by the low size bytes of store_data; all other bytes are preserved.
    - Next state is RESP.
  - RESP: resp_valid = 1 for one cycle; load_data and fault are valid. Next state is IDLE. req_ready = 0 in every state except IDLE.
- Transitions:
  - Load: IDLE -> READ -> RESP.
  - SD: IDLE -> WRITE -> RESP.
  - SB/SH/SW: IDLE -> READ -> WRITE -> RESP.
- Latency, counted from the accepting edge:
  - Load: resp_valid high 2 cycles later.
  - SD: 2 cycles.
  - Sub-word store: 3 cycles.
  - Fault: 1 cycle.
- Load extraction: select bytes [offset .. offset+size-1] from the captured word (little-endian). LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend; LD passes the word through.
- Back-to-back requests: no new request is accepted while busy. req_valid held through RESP is accepted in the following IDLE cycle, giving a minimum 1-cycle bubble.
- mem_addr holds its last value in IDLE/RESP; mem_write_en is never high outside WRITE.
- Addresses: the word index uses only byte_addr bits; upper bits beyond range trigger the out-of-range fault and never wrap.

Test Plan:
- SD at byte_addr 0x18, store_data 0x0123456789ABCDEF: mem_write_en high one cycle with mem_addr 3 and mem_wdata = store_data. A following LD at 0x18 returns 0x0123456789ABCDEF two cycles after acceptance.
- SB at 0x1D, data 0xFF, to word 3 holding 0x0123456789ABCDEF: word 3 becomes 0x0123FF6789ABCDEF. LB at 0x1D returns 0xFFFFFFFFFFFFFFFF; LBU at 0x1D returns 0x00000000000000FF.
- SH at 0x28, data 0x8001: word 5 low half = 0x8001. LH returns 0xFFFFFFFFFFFF8001; LHU returns 0x0000000000008001. LW at 0x2C returns the upper half of word 5, sign-extended.
- Faults each complete in 1 cycle with fault = 1 and no write:
  - LW at 0x1A (misaligned).
  - SD at 0x1000 (word 512 >= SIZE).
  - funct3 = 111 (illegal).
- Reset asserted during the WRITE cycle of an SB: mem_write_en drops immediately, outputs take reset values, and a subsequent LD shows the target word unchanged.
- Two requests with req_valid held continuously: the second is accepted only after resp_valid of the first, and req_ready is low for every intermediate cycle.
